pixel_readout_ctrl: RTL and testbench
=====================================

PIXEL_READOUT_CTRL -- requirements
Module: pixel_readout_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_ARRAY_WIDTH, default 4, number of columns (pixels per row).
REQ-002 SHALL have parameter PIXEL_ARRAY_HEIGHT, default 4, number of rows per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port row_select  input  PIXEL_ARRAY_HEIGHT  one-hot row select from the sensor state machine.
REQ-006 SHALL have port row_valid  input  1  one-cycle strobe: data_in holds converted row row_select.
REQ-007 SHALL have port data_in  input  PIXEL_ARRAY_WIDTH x 8  packed pixel codes; column c is in bits [8c+7:8c].
REQ-008 SHALL have port hold  output  1  stall request to the sensor state machine.
REQ-009 SHALL have port pix_data  output  8  current pixel code.
REQ-010 SHALL have port pix_row  output  clog2(PIXEL_ARRAY_HEIGHT), min 1  row index of pix_data.
REQ-011 SHALL have port pix_col  output  clog2(PIXEL_ARRAY_WIDTH), min 1  column index of pix_data.
REQ-012 SHALL have port pix_valid  output  1  pixel stream valid.
REQ-013 SHALL have port pix_ready  input  1  pixel stream ready from downstream.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-015 SHALL have port overrun  output  1  sticky row-drop error flag.

Function
REQ-016 SHALL buffer rows in a 2-entry row FIFO; each entry holds the full data_in word plus the row index.
REQ-017 SHALL capture on row_valid=1 only when row_select is nonzero; the row index is the lowest set bit, and an all-zero row_select is ignored.
REQ-018 SHALL present the head entry at pix_* with columns in order 0..W-1; a pixel transfers when pix_valid&pix_ready.
REQ-019 SHALL have latency as follows: with the FIFO empty, row_valid in cycle n gives pix_valid=1, col 0, in cycle n+1.
REQ-020 SHALL hold pix_data/pix_row/pix_col stable while pix_valid=1 and pix_ready=0.
REQ-021 SHALL pop the head entry on transfer of column W-1 and present the next entry's col 0 in the following cycle with no bubble.
REQ-022 SHALL assert hold combinationally whenever the FIFO holds 2 entries.
REQ-023 SHALL, on row_valid while full with no pop in the same cycle, drop the row, leave the FIFO unchanged and set overrun until reset.
REQ-024 SHALL, on row_valid while full coinciding with a pop, accept the row with no overrun.
REQ-025 SHALL pulse frame_done for one cycle, in the cycle after transfer of col W-1 of row H-1.
REQ-026 SHALL not require rows to arrive in order; pix_row always reflects the captured index.

Reset
REQ-027 SHALL, while reset=1, empty the FIFO, set the column counter to 0 and drive hold, pix_valid, pix_data, pix_row, pix_col, frame_done and overrun to 0.
REQ-028 SHALL, on reset asserted mid-stream, discard the partial row with no frame_done; the first valid pixel after release comes from a new row_valid.

Configuration
REQ-029 SHALL, with macro PIXEL_READOUT_SOF_EOL_EN defined, add output pix_sof (1 = row 0, col 0) and output pix_eol (1 = col W-1), both qualified by pix_valid and reset to 0.
REQ-030 SHALL, without PIXEL_READOUT_SOF_EOL_EN, omit both ports and leave all other behaviour identical.

Verification
REQ-031 SHALL verify single row: W=H=4, row_select=0001, data_in=0x44332211, pix_ready=1 -> pix_data 11,22,33,44 in cycles n+1..n+4, row 0, cols 0..3.
REQ-032 SHALL verify backpressure: pix_ready=0 for 3 cycles at col 2 -> pix_data held at 0x33, col 2, then the stream resumes.
REQ-033 SHALL verify full: three row_valid strobes with pix_ready=0 -> hold=1 after the 2nd, 3rd row dropped, overrun=1, and the first two rows later stream intact.
REQ-034 SHALL verify simultaneous: FIFO full and row_valid in the same cycle as the col-3 transfer -> row accepted, overrun stays 0.
REQ-035 SHALL verify frame: rows 0..3 streamed -> a single frame_done pulse in the cycle after row 3 col 3; with the macro, pix_sof only on row 0 col 0 and pix_eol on each col 3.
REQ-036 SHALL verify reset mid-row at col 1 -> all outputs 0 immediately, no frame_done, and the FIFO empty after release.

Source files
------------

// File: rtl/pixel_readout_ctrl.sv
// Row-buffered pixel serializer: a 2-entry row FIFO is drained one pixel at a time onto a valid/ready stream.
// Optional macro PIXEL_READOUT_SOF_EOL_EN adds the pix_sof / pix_eol stream markers.
module pixel_readout_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int COL_W = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1,
  localparam int DW    = PIXEL_ARRAY_WIDTH * 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0] row_select,
  input  logic                          row_valid,
  input  logic [DW-1:0]                 data_in,
  output logic                          hold,
  output logic [7:0]                    pix_data,
  output logic [ROW_W-1:0]              pix_row,
  output logic [COL_W-1:0]              pix_col,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          frame_done,
  output logic                          overrun
`ifdef PIXEL_READOUT_SOF_EOL_EN
  ,
  output logic                          pix_sof,
  output logic                          pix_eol
`endif
);

  logic [DW-1:0]    r_mem_data [2];
  logic [ROW_W-1:0] r_mem_row  [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [COL_W-1:0] r_col;
  logic             r_frame_done;
  logic             r_overrun;

  logic             w_sel_any;
  logic [ROW_W-1:0] w_sel_idx;
  logic             w_valid;
  logic             w_full;
  logic             w_xfer;
  logic             w_last_col;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [DW-1:0]    w_head_data;
  logic [ROW_W-1:0] w_head_row;

  // Descending scan so the lowest set bit of row_select wins.
  always_comb begin
    w_sel_idx = '0;
    for (int i = PIXEL_ARRAY_HEIGHT - 1; i >= 0; i--) begin
      if (row_select[i]) w_sel_idx = ROW_W'(i);
    end
  end

  assign w_sel_any   = |row_select;
  assign w_valid     = (r_count != 2'd0);
  assign w_full      = (r_count == 2'd2);
  assign w_xfer      = w_valid & pix_ready;
  assign w_last_col  = (r_col == COL_W'(PIXEL_ARRAY_WIDTH - 1));
  assign w_pop       = w_xfer & w_last_col;
  // A full FIFO still accepts a row when the head row is leaving this same cycle.
  assign w_push      = row_valid & w_sel_any & (~w_full | w_pop);
  assign w_drop      = row_valid & w_sel_any & w_full & ~w_pop;
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_row  = r_mem_row[r_rd_ptr];

  assign hold       = w_full;
  assign pix_valid  = w_valid;
  assign pix_data   = w_valid ? w_head_data[{r_col, 3'b000} +: 8] : 8'd0;
  assign pix_row    = w_valid ? w_head_row : '0;
  assign pix_col    = w_valid ? r_col : '0;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

`ifdef PIXEL_READOUT_SOF_EOL_EN
  assign pix_sof = w_valid & (w_head_row == '0) & (r_col == '0);
  assign pix_eol = w_valid & w_last_col;
`endif

  // Row storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= data_in;
      r_mem_row[r_wr_ptr]  <= w_sel_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= w_pop & (w_head_row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));
      if (w_drop) r_overrun <= 1'b1;
      if (w_xfer) r_col <= w_last_col ? '0 : r_col + 1'b1;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl (W=H=4): vector table plus hand-written full/simultaneous/reset sequences.
module tb_pixel_readout_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  row_select;
  logic        row_valid;
  logic [31:0] data_in;
  logic        hold;
  logic [7:0]  pix_data;
  logic [1:0]  pix_row;
  logic [1:0]  pix_col;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;
  logic        overrun;
`ifdef PIXEL_READOUT_SOF_EOL_EN
  logic        pix_sof;
  logic        pix_eol;
`endif

  int total = 0;
  int bad   = 0;

  pixel_readout_ctrl #(.PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_select (row_select),
    .row_valid  (row_valid),
    .data_in    (data_in),
    .hold       (hold),
    .pix_data   (pix_data),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .overrun    (overrun)
`ifdef PIXEL_READOUT_SOF_EOL_EN
    ,
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [3:0] sel;
    logic [31:0] din;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] er;
    logic [1:0] ec;
    logic       eh;
    logic       efd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rv, input logic [3:0] sel, input logic [31:0] din, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic [1:0] er, input logic [1:0] ec,
                     input logic eh, input logic efd);
    vec_t v;
    v.rv = rv; v.sel = sel; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.er = er; v.ec = ec; v.eh = eh; v.efd = efd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    row_valid = 1'b0;
    row_select = 4'b0000;
    data_in = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_hold",  32'(hold), 32'd0);
    chk("rst_data",  32'(pix_data), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    reset = 1'b0;
  endtask

  task automatic push(input logic [3:0] sel, input logic [31:0] din);
    row_valid = 1'b1;
    row_select = sel;
    data_in = din;
  endtask

  initial begin
    reset = 1'b1;
    row_valid = 1'b0;
    row_select = 4'b0000;
    data_in = 32'h0;
    pix_ready = 1'b1;

    // rv sel din rdy | valid data row col hold fd
    add(1, 4'b0001, 32'h44332211, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h11, 0, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h22, 0, 1, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h33, 0, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h44, 0, 3, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 4'b0010, 32'h44332211, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h11, 1, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h22, 1, 1, 0, 0);
    add(0, 4'b0000, 32'h0,        0, 1, 8'h33, 1, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        0, 1, 8'h33, 1, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        0, 1, 8'h33, 1, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h33, 1, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h44, 1, 3, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 4'b1000, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 4'b1100, 32'h0D0C0B0A, 1, 1, 8'hAA, 3, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'hBB, 3, 1, 1, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'hCC, 3, 2, 1, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'hDD, 3, 3, 1, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h0A, 2, 0, 0, 1);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h0B, 2, 1, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h0C, 2, 2, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 1, 8'h0D, 2, 3, 0, 0);
    add(1, 4'b0000, 32'hFFFFFFFF, 1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 0, 0, 0);

    do_reset();

    foreach (tbl[i]) begin
      row_valid = tbl[i].rv;
      row_select = tbl[i].sel;
      data_in = tbl[i].din;
      pix_ready = tbl[i].rdy;
      $display("vec %0d: valid=%0b data=%02h row=%0d col=%0d hold=%0b fd=%0b",
               i, pix_valid, pix_data, pix_row, pix_col, hold, frame_done);
      chk($sformatf("v%0d_valid", i), 32'(pix_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_data", i),  32'(pix_data),  32'(tbl[i].ed));
      chk($sformatf("v%0d_row", i),   32'(pix_row),   32'(tbl[i].er));
      chk($sformatf("v%0d_col", i),   32'(pix_col),   32'(tbl[i].ec));
      chk($sformatf("v%0d_hold", i),  32'(hold),      32'(tbl[i].eh));
      chk($sformatf("v%0d_fd", i),    32'(frame_done), 32'(tbl[i].efd));
      chk($sformatf("v%0d_ovr", i),   32'(overrun),   32'd0);
`ifdef PIXEL_READOUT_SOF_EOL_EN
      chk($sformatf("v%0d_sof", i), 32'(pix_sof),
          32'(tbl[i].ev && tbl[i].er == 2'd0 && tbl[i].ec == 2'd0));
      chk($sformatf("v%0d_eol", i), 32'(pix_eol), 32'(tbl[i].ev && tbl[i].ec == 2'd3));
`endif
      step();
    end

    // Full FIFO with a stalled sink: third row is dropped and overrun sticks.
    do_reset();
    pix_ready = 1'b0;
    push(4'b0001, 32'h04030201);
    chk("full_h0", 32'(hold), 32'd0);
    step();
    push(4'b0010, 32'h14131211);
    chk("full_v1", 32'(pix_valid), 32'd1);
    chk("full_h1", 32'(hold), 32'd0);
    step();
    push(4'b0100, 32'h24232221);
    chk("full_h2", 32'(hold), 32'd1);
    chk("full_ovr0", 32'(overrun), 32'd0);
    step();
    row_valid = 1'b0;
    row_select = 4'b0000;
    pix_ready = 1'b1;
    chk("full_ovr1", 32'(overrun), 32'd1);
    for (int k = 0; k < 8; k++) begin
      $display("full %0d: data=%02h row=%0d col=%0d hold=%0b", k, pix_data, pix_row, pix_col, hold);
      chk($sformatf("full%0d_data", k), 32'(pix_data), (k < 4) ? 32'(8'h01 + k) : 32'(8'h11 + k - 4));
      chk($sformatf("full%0d_row", k), 32'(pix_row), 32'(k / 4));
      chk($sformatf("full%0d_col", k), 32'(pix_col), 32'(k % 4));
      chk($sformatf("full%0d_hold", k), 32'(hold), 32'(k < 4));
      step();
    end
    chk("full_empty", 32'(pix_valid), 32'd0);
    chk("full_ovr_sticky", 32'(overrun), 32'd1);

    // Row arrives while full in the same cycle as the head row's last transfer.
    do_reset();
    pix_ready = 1'b0;
    push(4'b0001, 32'h04030201);
    step();
    push(4'b0010, 32'h14131211);
    step();
    row_valid = 1'b0;
    row_select = 4'b0000;
    chk("sim_hold", 32'(hold), 32'd1);
    pix_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) push(4'b0100, 32'h24232221);
      else begin
        row_valid = 1'b0;
        row_select = 4'b0000;
      end
      $display("sim %0d: data=%02h row=%0d col=%0d hold=%0b ovr=%0b", k, pix_data, pix_row, pix_col, hold, overrun);
      chk($sformatf("sim%0d_data", k), 32'(pix_data), 32'(8'h01 + (k / 4) * 16 + (k % 4)));
      chk($sformatf("sim%0d_row", k), 32'(pix_row), 32'(k / 4));
      chk($sformatf("sim%0d_hold", k), 32'(hold), 32'(k < 8));
      chk($sformatf("sim%0d_ovr", k), 32'(overrun), 32'd0);
      step();
    end
    chk("sim_empty", 32'(pix_valid), 32'd0);
    chk("sim_fd", 32'(frame_done), 32'd0);

    // Reset asserted mid-row on row 3: partial row discarded, no frame_done.
    do_reset();
    pix_ready = 1'b1;
    push(4'b1000, 32'h0D0C0B0A);
    step();
    row_valid = 1'b0;
    row_select = 4'b0000;
    chk("mid_d0", 32'(pix_data), 32'h0A);
    step();
    chk("mid_c1", 32'(pix_col), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    $display("midreset: valid=%0b data=%02h col=%0d", pix_valid, pix_data, pix_col);
    chk("mid_valid", 32'(pix_valid), 32'd0);
    chk("mid_data",  32'(pix_data), 32'd0);
    chk("mid_col",   32'(pix_col), 32'd0);
    chk("mid_row",   32'(pix_row), 32'd0);
    chk("mid_hold",  32'(hold), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post%0d_valid", k), 32'(pix_valid), 32'd0);
      chk($sformatf("post%0d_fd", k), 32'(frame_done), 32'd0);
      step();
    end
    push(4'b0001, 32'h44332211);
    step();
    row_valid = 1'b0;
    row_select = 4'b0000;
    chk("post_valid", 32'(pix_valid), 32'd1);
    chk("post_data", 32'(pix_data), 32'h11);
    chk("post_col", 32'(pix_col), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
